tron_cpu: RTL and testbench

Multi-cycle 16-bit CR16-style processor core. It has 16 general registers, an ALU/shifter, a 5-bit flag register and a PC. Instructions arrive on an external `instruction` port and are latched at fetch. The core exposes the PC (`addressOut`) and the write-back bus (`busOutput`). It is the top of the Tron CPU and contains a controller and a datapath.

---
 rtl/tron_pkg.sv | 82 ++++++++
 rtl/tron_controller.sv | 53 +++++
 rtl/tron_datapath.sv | 93 +++++++++
 rtl/tron_cpu.sv | 43 ++++
 tb/tb_tron_cpu.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/tron_pkg.sv
// rtl/tron_pkg.sv - opcode/ext codes, FSM states, flag indices and decode helper for the Tron core
package tron_pkg;

  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_JAL   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_LSH = 4'b0100;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_JAL = 4'b1000;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  localparam int FLG_L = 0;
  localparam int FLG_C = 1;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 4;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_LUI_WB} state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADD, C_SUB, C_CMP, C_AND, C_OR, C_XOR, C_MOV,
    C_LSH, C_LSHI, C_JAL, C_LUI
  } cls_t;

  typedef struct packed {
    cls_t cls;
    logic use_imm;
    logic sext;
  } dec_t;

  // Immediate forms share the register-form class; only operand B differs.
  function automatic dec_t decode(input logic [15:0] ir);
    dec_t d;
    d.cls     = C_NOP;
    d.use_imm = 1'b0;
    d.sext    = 1'b0;
    case (ir[15:12])
      OP_RR: begin
        case (ir[7:4])
          EXT_ADD: d.cls = C_ADD;
          EXT_SUB: d.cls = C_SUB;
          EXT_CMP: d.cls = C_CMP;
          EXT_AND: d.cls = C_AND;
          EXT_OR:  d.cls = C_OR;
          EXT_XOR: d.cls = C_XOR;
          EXT_MOV: d.cls = C_MOV;
          default: d.cls = C_NOP;
        endcase
      end
      OP_ADDI: begin d.cls = C_ADD; d.use_imm = 1'b1; d.sext = 1'b1; end
      OP_SUBI: begin d.cls = C_SUB; d.use_imm = 1'b1; d.sext = 1'b1; end
      OP_CMPI: begin d.cls = C_CMP; d.use_imm = 1'b1; d.sext = 1'b1; end
      OP_MOVI: begin d.cls = C_MOV; d.use_imm = 1'b1; d.sext = 1'b1; end
      OP_ANDI: begin d.cls = C_AND; d.use_imm = 1'b1; end
      OP_ORI:  begin d.cls = C_OR;  d.use_imm = 1'b1; end
      OP_XORI: begin d.cls = C_XOR; d.use_imm = 1'b1; end
      OP_LUI:  d.cls = C_LUI;
      OP_SHIFT: begin
        if (ir[7:4] == EXT_LSH)      d.cls = C_LSH;
        else if (ir[7:5] == 3'b000)  d.cls = C_LSHI;
      end
      OP_JAL: if (ir[7:4] == EXT_JAL) d.cls = C_JAL;
      default: d.cls = C_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tron_controller.sv
// rtl/tron_controller.sv - FETCH/DECODE/EXECUTE(/LUI_WB) sequencer and instruction decode
module tron_controller
  import tron_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  output state_t      state,
  output dec_t        dec,
  output logic        ir_load,
  output logic        flag_load,
  output logic        pc_jump,
  output logic        regWrite
);

  state_t state_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    dec        = decode(ir);
    state_next = S_FETCH;
    ir_load    = 1'b0;
    flag_load  = 1'b0;
    pc_jump    = 1'b0;
    regWrite   = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        flag_load  = (dec.cls == C_ADD) || (dec.cls == C_SUB) || (dec.cls == C_CMP);
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        // LUI defers its write by one state.
        regWrite   = (dec.cls != C_NOP) && (dec.cls != C_CMP) && (dec.cls != C_LUI);
        pc_jump    = (dec.cls == C_JAL);
        state_next = (dec.cls == C_LUI) ? S_LUI_WB : S_FETCH;
      end
      S_LUI_WB: begin
        regWrite   = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/tron_datapath.sv
// rtl/tron_datapath.sv - register file, ALU/shifter, flag register, PC and IR
module tron_datapath
  import tron_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  dec_t        dec,
  input  logic        ir_load,
  input  logic        flag_load,
  input  logic        pc_jump,
  input  logic        reg_write,
  output logic [15:0] ir,
  output logic [15:0] addressOut,
  output logic [15:0] busOutput
);

  logic [15:0] regs [16];
  logic [15:0] pc;
  logic [15:0] flagreg;
  logic [15:0] a, rs, b, imm, neg_amt, shifted, flags_next;
  logic [16:0] sum, diff;

  assign addressOut = pc;

  always_comb begin
    a          = regs[ir[11:8]];
    rs         = regs[ir[3:0]];
    imm        = dec.sext ? {{8{ir[7]}}, ir[7:0]} : {8'h00, ir[7:0]};
    b          = dec.use_imm ? imm : rs;
    sum        = {1'b0, a} + {1'b0, b};
    diff       = {1'b0, a} - {1'b0, b};
    neg_amt    = 16'd0 - rs;
    shifted    = 16'h0000;
    flags_next = 16'h0000;
    busOutput  = 16'h0000;

    // Shift count in Rsrc is signed: 0..15 left, -1..-15 right, otherwise zero.
    if (rs[15:4] == 12'h000)
      shifted = a << rs[3:0];
    else if (rs[15:4] == 12'hFFF && rs[3:0] != 4'h0)
      shifted = a >> neg_amt[3:0];

    case (dec.cls)
      C_ADD: begin
        flags_next[FLG_C] = sum[16];
        flags_next[FLG_F] = (a[15] == b[15]) && (sum[15] != a[15]);
      end
      C_SUB: begin
        flags_next[FLG_C] = diff[16];
        flags_next[FLG_F] = (a[15] != b[15]) && (diff[15] != a[15]);
      end
      C_CMP: begin
        flags_next[FLG_L] = a < b;
        flags_next[FLG_Z] = a == b;
        flags_next[FLG_N] = $signed(a) < $signed(b);
      end
      default: flags_next = 16'h0000;
    endcase

    case (dec.cls)
      C_ADD:   busOutput = sum[15:0];
      C_SUB:   busOutput = diff[15:0];
      C_AND:   busOutput = a & b;
      C_OR:    busOutput = a | b;
      C_XOR:   busOutput = a ^ b;
      C_MOV:   busOutput = b;
      C_LSH:   busOutput = shifted;
      C_LSHI:  busOutput = a << ir[3:0];
      C_JAL:   busOutput = pc;
      C_LUI:   busOutput = {ir[7:0], 8'h00};
      default: busOutput = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= 16'h0000;
      ir      <= 16'h0000;
      flagreg <= 16'h0000;
      for (int i = 0; i < 16; i++) regs[i] <= 16'(i);
    end else begin
      if (ir_load) begin
        ir <= instruction;
        pc <= pc + 16'd1;
      end
      if (pc_jump)   pc <= rs;
      if (flag_load) flagreg <= flags_next;
      if (reg_write) regs[ir[11:8]] <= busOutput;
    end
  end

endmodule

// File: rtl/tron_cpu.sv
// rtl/tron_cpu.sv - multi-cycle 16-bit Tron core: controller plus datapath
module tron_cpu
  import tron_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  output logic [15:0] addressOut,
  output logic [15:0] busOutput
);

  state_t      state;
  dec_t        dec;
  logic [15:0] ir;
  logic        ir_load, flag_load, pc_jump, regWrite;

  tron_controller fsmController (
    .clk       (clk),
    .reset     (reset),
    .ir        (ir),
    .state     (state),
    .dec       (dec),
    .ir_load   (ir_load),
    .flag_load (flag_load),
    .pc_jump   (pc_jump),
    .regWrite  (regWrite)
  );

  tron_datapath UUTdatapath (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .dec         (dec),
    .ir_load     (ir_load),
    .flag_load   (flag_load),
    .pc_jump     (pc_jump),
    .reg_write   (regWrite),
    .ir          (ir),
    .addressOut  (addressOut),
    .busOutput   (busOutput)
  );

endmodule

// File: tb/tb_tron_cpu.sv
// tb/tb_tron_cpu.sv - directed self-checking bench for tron_cpu
module tb_tron_cpu;
  import tron_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] addressOut;
  logic [15:0] busOutput;
  logic [15:0] exp_pc;
  int          checks;
  int          failures;

  tron_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .addressOut  (addressOut),
    .busOutput   (busOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an instruction while in FETCH; return on the negedge just before the
  // edge that leaves the final state (EXECUTE, or LUI_WB when edges == 4).
  task automatic run(input logic [15:0] instr, input int edges);
    instruction = instr;
    exp_pc      = exp_pc + 16'd1;
    repeat (edges - 1) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic restore_r1();
    run(16'hD101, 3);
    adv();
  endtask

  task automatic alu(input string tag, input logic [15:0] instr, input logic [15:0] exp_bus);
    run(instr, 3);
    chk({tag, "_pc"}, addressOut, exp_pc);
    chk({tag, "_rw"}, {15'd0, dut.fsmController.regWrite}, 16'h0001);
    chk({tag, "_bus"}, busOutput, exp_bus);
    adv();
    restore_r1();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_pc      = 16'h0000;
    reset       = 1'b0;
    instruction = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_pc", addressOut, 16'h0000);
    chk("rst_rw", {15'd0, dut.fsmController.regWrite}, 16'h0000);
    chk("rst_flags", dut.UUTdatapath.flagreg, 16'h0000);
    chk("rst_state", {14'd0, dut.fsmController.state}, {14'd0, S_FETCH});
    reset = 1'b1;

    alu("add", 16'h0152, 16'h0003);

    run(16'h5193, 3);
    chk("addi_bus", busOutput, 16'hFF94);
    chk("addi_flags", dut.UUTdatapath.flagreg, 16'h0000);
    adv(); restore_r1();

    run(16'h0192, 3);
    chk("sub_bus", busOutput, 16'hFFFF);
    chk("sub_flags", dut.UUTdatapath.flagreg, 16'h0002);
    adv(); restore_r1();

    run(16'h9101, 3);
    chk("subi_bus", busOutput, 16'h0000);
    chk("subi_flags", dut.UUTdatapath.flagreg, 16'h0000);
    adv(); restore_r1();

    run(16'h01B1, 3);
    chk("cmp_rw", {15'd0, dut.fsmController.regWrite}, 16'h0000);
    chk("cmp_flags", dut.UUTdatapath.flagreg, 16'h0008);
    adv(); restore_r1();

    run(16'hB102, 3);
    chk("cmpi_rw", {15'd0, dut.fsmController.regWrite}, 16'h0000);
    chk("cmpi_flags", dut.UUTdatapath.flagreg, 16'h0011);
    adv(); restore_r1();

    alu("and",   16'h0113, 16'h0001);
    alu("mov",   16'h01D5, 16'h0005);
    alu("or",    16'h0122, 16'h0003);
    alu("ori",   16'h210E, 16'h000F);
    alu("xor",   16'h013E, 16'h000F);
    alu("xori",  16'h310E, 16'h000F);
    alu("lsh",   16'h8143, 16'h0008);
    alu("lshi",  16'h8101, 16'h0002);
    alu("lshi4", 16'h8111, 16'h0002);

    while (exp_pc != 16'h0020) begin
      run(16'h0000, 3);
      chk("nop_rw", {15'd0, dut.fsmController.regWrite}, 16'h0000);
      adv();
    end

    run(16'hF101, 3);
    chk("lui_ex_rw", {15'd0, dut.fsmController.regWrite}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("lui_pc", addressOut, 16'h0021);
    chk("lui_rw", {15'd0, dut.fsmController.regWrite}, 16'h0001);
    chk("lui_bus", busOutput, 16'h0100);
    adv();
    restore_r1();

    run(16'h4182, 3);
    chk("jal_pc_ex", addressOut, 16'h0023);
    chk("jal_bus", busOutput, 16'h0023);
    chk("jal_rw", {15'd0, dut.fsmController.regWrite}, 16'h0001);
    adv();
    chk("jal_target", addressOut, 16'h0002);
    exp_pc = 16'h0002;

    run(16'hF37F, 4);
    chk("lui3_bus", busOutput, 16'h7F00);
    adv();
    run(16'h0353, 3);
    chk("ovf_bus", busOutput, 16'hFE00);
    chk("ovf_flags", dut.UUTdatapath.flagreg, 16'h0004);
    adv();
    run(16'h0353, 3);
    chk("carry_bus", busOutput, 16'hFC00);
    chk("carry_flags", dut.UUTdatapath.flagreg, 16'h0002);
    adv();

    run(16'hD4FE, 3); adv();
    run(16'h8544, 3);
    chk("lsh_right", busOutput, 16'h0001);
    adv();
    run(16'hD4F0, 3); adv();
    run(16'h8544, 3);
    chk("lsh_oor", busOutput, 16'h0000);
    adv();

    run(16'h01D5, 3);
    chk("abort_rw_pre", {15'd0, dut.fsmController.regWrite}, 16'h0001);
    reset = 1'b0;
    #1;
    chk("abort_pc", addressOut, 16'h0000);
    chk("abort_rw", {15'd0, dut.fsmController.regWrite}, 16'h0000);
    chk("abort_flags", dut.UUTdatapath.flagreg, 16'h0000);
    chk("abort_state", {14'd0, dut.fsmController.state}, {14'd0, S_FETCH});
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    exp_pc = 16'h0000;
    alu("post_rst_add", 16'h0152, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
